// File: rtl/uart_tx_dev_if.sv
// Bridge device-side bus for the serial transmitter.
//   Dev_Addr : word select (0 CTRL, 1 DIVISOR, 2 TXDATA, 3 STATUS)
//   WE       : write enable for this device
//   DataIn   : write data
//   RD       : read data of the addressed register
//   IRQ      : level interrupt towards the bridge
interface uart_tx_dev_if;
  logic [3:2]  Dev_Addr;
  logic        WE;
  logic [31:0] DataIn;
  logic [31:0] RD;
  logic        IRQ;

  modport master (
    output Dev_Addr, WE, DataIn,
    input  RD, IRQ
  );

  modport slave (
    input  Dev_Addr, WE, DataIn,
    output RD, IRQ
  );
endinterface

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 serial transmitter with a small transmit FIFO.
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   bus   : device bus (address, write strobe, write data, read data, IRQ)
//   txd   : registered serial output, idle high
module uart_tx_dev #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic         clk,
  input  logic         reset,
  uart_tx_dev_if.slave bus,
  output logic         txd
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     div_q, div_d;          // per-frame shadow of the divisor
  logic [15:0]     divisor_q, divisor_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic            txd_q, txd_d;
  logic            en_q, en_d, ie_q, ie_d;
  logic            ovf_q, ovf_d, done_q, done_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic        wr_ctrl, wr_div, wr_data, wr_stat;
  logic        fifo_full, fifo_empty;
  logic        pop, push, ovf_set, done_set, bit_end;
  logic [15:0] div_eff;
  logic [2:0]  count3;
  logic        unused_data;

  assign wr_ctrl = bus.WE && (bus.Dev_Addr == 2'd0);
  assign wr_div  = bus.WE && (bus.Dev_Addr == 2'd1);
  assign wr_data = bus.WE && (bus.Dev_Addr == 2'd2);
  assign wr_stat = bus.WE && (bus.Dev_Addr == 2'd3);

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign bit_end    = (cnt_q == 16'd0);
  assign div_eff    = (divisor_q == 16'd0) ? 16'd1 : divisor_q;
  assign count3     = 3'(count_q);
  assign unused_data = ^bus.DataIn[31:16];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= DIV_RESET;
      divisor_q <= DIV_RESET;
      shift_q   <= '0;
      bit_q     <= '0;
      txd_q     <= 1'b1;
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      divisor_q <= divisor_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      txd_q     <= txd_d;
      en_q      <= en_d;
      ie_q      <= ie_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage needs no reset; the count marks valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.DataIn[7:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    pop      = 1'b0;
    done_set = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en_q && !fifo_empty) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end && (bit_q == 3'd7)) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          // Chain straight into the next start bit when more data is queued.
          if (en_q && !fifo_empty) begin
            pop     = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
          done_set = fifo_empty;
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      div_d   = div_eff;
      cnt_d   = div_eff - 16'd1;
      bit_d   = '0;
    end else if (state_q != StIdle) begin
      if (bit_end) begin
        cnt_d = div_q - 16'd1;
        if (state_q == StData) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end

    // A pop in the same cycle frees the slot for a push into a full FIFO.
    push     = wr_data && (!fifo_full || pop);
    ovf_set  = wr_data && !push;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    wr_ptr_d = wr_ptr_q + PtrW'(push);

    en_d      = wr_ctrl ? bus.DataIn[0] : en_q;
    ie_d      = wr_ctrl ? bus.DataIn[1] : ie_q;
    divisor_d = wr_div ? bus.DataIn[15:0] : divisor_q;
    // Set beats clear on both sticky bits.
    ovf_d  = ovf_set | (ovf_q & ~(wr_stat & bus.DataIn[6]));
    done_d = done_set | (done_q & ~(wr_stat & bus.DataIn[7]) & ~push);
  end

  // Outputs: line level follows the upcoming state; reads come straight from registers.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase

    bus.RD = '0;
    unique case (bus.Dev_Addr)
      2'd0:    bus.RD = {30'd0, ie_q, en_q};
      2'd1:    bus.RD = {16'd0, divisor_q};
      2'd2:    bus.RD = '0;
      default: bus.RD = {24'd0, done_q, ovf_q, count3, fifo_empty, fifo_full,
                         (state_q != StIdle)};
    endcase

    bus.IRQ = ie_q & done_q;
  end

  assign txd = txd_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
module tb_uart_tx_dev;

  localparam int Depth = 4;

  logic clk = 1'b0;
  logic reset;
  logic txd;

  uart_tx_dev_if bus ();

  uart_tx_dev #(
    .FIFO_DEPTH(Depth),
    .DIV_RESET (16'd434)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .txd  (txd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: the line is a queue of per-clock levels for the frames in flight.
  bit [7:0]    m_fifo[$];
  bit          m_line[$];
  bit          m_en   = 1'b0;
  bit          m_ie   = 1'b0;
  bit          m_ovf  = 1'b0;
  bit          m_done = 1'b0;
  logic [15:0] m_div  = 16'd434;
  bit          m_was_busy, m_set_done;
  bit [7:0]    m_byte;
  bit [9:0]    m_frame;
  int          m_period;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_fifo.delete();
      m_line.delete();
      m_en   = 1'b0;
      m_ie   = 1'b0;
      m_ovf  = 1'b0;
      m_done = 1'b0;
      m_div  = 16'd434;
    end else begin
      m_was_busy = (m_line.size() != 0);
      if (m_was_busy) void'(m_line.pop_front());
      m_set_done = 1'b0;
      if (m_line.size() == 0) begin
        if (m_en && m_fifo.size() != 0) begin
          m_byte   = m_fifo.pop_front();
          m_period = (m_div == 16'd0) ? 1 : int'(m_div);
          m_frame  = {1'b1, m_byte, 1'b0};
          for (int i = 0; i < 10 * m_period; i++) m_line.push_back(m_frame[i / m_period]);
        end else if (m_was_busy && m_fifo.size() == 0) begin
          m_set_done = 1'b1;
        end
      end
      if (bus.WE) begin
        case (bus.Dev_Addr)
          2'd0: begin
            m_en = bus.DataIn[0];
            m_ie = bus.DataIn[1];
          end
          2'd1: m_div = bus.DataIn[15:0];
          2'd2: begin
            if (m_fifo.size() < Depth) begin
              m_fifo.push_back(bus.DataIn[7:0]);
              m_done = 1'b0;
            end else begin
              m_ovf = 1'b1;
            end
          end
          default: begin
            if (bus.DataIn[7]) m_done = 1'b0;
            if (bus.DataIn[6]) m_ovf = 1'b0;
          end
        endcase
      end
      if (m_set_done) m_done = 1'b1;
    end
  end

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    int c;
    r = '0;
    c = m_fifo.size();
    case (a)
      2'd0: r = {30'd0, m_ie, m_en};
      2'd1: r = {16'd0, m_div};
      2'd2: r = '0;
      default: begin
        r[0]   = (m_line.size() != 0);
        r[1]   = (c == Depth);
        r[2]   = (c == 0);
        r[5:3] = c[2:0];
        r[6]   = m_ovf;
        r[7]   = m_done;
      end
    endcase
    return r;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("txd", {31'd0, txd}, {31'd0, (m_line.size() != 0) ? m_line[0] : 1'b1});
    chk("irq", {31'd0, bus.IRQ}, {31'd0, m_ie & m_done});
    chk("rd", bus.RD, m_read(bus.Dev_Addr));
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Dev_Addr = a;
    bus.DataIn   = d;
    bus.WE       = 1'b1;
    @(posedge clk);
    #2;
    bus.WE = 1'b0;
  endtask

  task automatic rd_lit(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.Dev_Addr = a;
    #1;
    chk(name, bus.RD, exp);
  endtask

  // Count edges until STATUS.DONE shows, bounded; an expired bound reads as a wrong count.
  task automatic wait_done(input string name, input int exp);
    int k;
    k = 0;
    bus.Dev_Addr = 2'd3;
    while (k < 400) begin
      @(posedge clk);
      #2;
      k++;
      if (bus.RD[7]) break;
    end
    chk(name, k, exp);
  endtask

  logic [9:0] pat;
  logic       got_bits [40];
  int         k;

  initial begin
    reset        = 1'b0;
    bus.WE       = 1'b0;
    bus.Dev_Addr = 2'd0;
    bus.DataIn   = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    rd_lit("rst_div", 2'd1, 32'd434);
    rd_lit("rst_status", 2'd3, 32'h04);
    chk("rst_txd", {31'd0, txd}, 32'd1);

    // Single 0xA5 frame at 4 clocks per bit.
    wr(2'd0, 32'h1);
    wr(2'd1, 32'd4);
    wr(2'd2, 32'hA5);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      got_bits[i] = txd;
    end
    pat = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) chk("a5_bit", {31'd0, got_bits[i]}, {31'd0, pat[i / 4]});
    @(posedge clk);
    #2;
    rd_lit("a5_status", 2'd3, 32'h84);

    // Three back-to-back frames at DIV=2 with interrupt enabled.
    wr(2'd3, 32'h80);
    wr(2'd0, 32'h3);
    wr(2'd1, 32'd2);
    wr(2'd2, 32'h01);
    wr(2'd2, 32'h02);
    wr(2'd2, 32'h03);
    k = 0;
    while (k < 200) begin
      @(posedge clk);
      #2;
      k++;
      if (bus.IRQ) break;
    end
    chk("irq_latency", k, 59);
    wr(2'd3, 32'h80);
    chk("irq_clear", {31'd0, bus.IRQ}, 32'd0);

    // Overflow with the transmitter disabled.
    wr(2'd0, 32'h0);
    for (int i = 1; i <= 5; i++) wr(2'd2, 32'h11 * i);
    rd_lit("ovf_status", 2'd3, 32'h62);
    wr(2'd3, 32'h40);
    rd_lit("ovf_clear", 2'd3, 32'h22);

    // Enable, then push while full in the very cycle the first pop happens.
    wr(2'd0, 32'h1);
    wr(2'd2, 32'h66);
    rd_lit("simul_status", 2'd3, 32'h23);
    wait_done("five_frames_len", 100);

    // DIV=0 acts as 1; a divisor change mid-frame applies to the next frame.
    wr(2'd1, 32'd0);
    wr(2'd2, 32'h0F);
    wr(2'd2, 32'hF0);
    wr(2'd1, 32'd8);
    wait_done("div_change_len", 89);

    // Reset in the middle of a start bit.
    wr(2'd2, 32'h3C);
    repeat (5) begin
      @(posedge clk);
      #2;
    end
    chk("pre_rst_txd", {31'd0, txd}, 32'd0);
    #1 reset = 1'b0;
    #1 chk("mid_rst_txd", {31'd0, txd}, 32'd1);
    rd_lit("mid_rst_status", 2'd3, 32'h04);
    @(posedge clk);
    #2 reset = 1'b1;
    rd_lit("post_rst_div", 2'd1, 32'd434);
    rd_lit("post_rst_ctrl", 2'd0, 32'd0);
    repeat (4) @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
